// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and sizing helpers for multiplexed display blocks.
// Segment order is {g,f,e,d,c,b,a}; all patterns are the active-high form.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Width of a counter running 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-decimal codes 10..15 show a dash so corrupt input is visible on the display.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-segment driver: shadows a packed BCD vector, scans one digit
// per SCAN_DIV cycles onto a shared registered segment bus, optional leading-zero blanking.
module bcd_seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int   IW     = idx_width(NUM_DIGITS);
    localparam int   PW     = idx_width(SCAN_DIV);
    localparam logic INVERT = (COMMON_ANODE != 0);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("bcd_seg_scan: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("bcd_seg_scan: SCAN_DIV must be >= 2");
    end

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [3:0]              cur_digit_p0;
    logic                    cur_lz_p0;
    logic                    blank_p0;
    logic [6:0]              pat_p0;
    logic [6:0]              seg_p0;
    logic [NUM_DIGITS-1:0]   en_p0;

    // Scan timing: prescaler sets dwell time, index steps on its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= bcd_in;
        end
    end

    // lead_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run          = run & (shadow[4*k +: 4] == 4'd0);
            lead_zero[k] = run;
        end
    end

    always_comb begin
        cur_digit_p0 = 4'd0;
        cur_lz_p0    = 1'b0;
        en_p0        = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_digit_p0 = shadow[4*k +: 4];
                cur_lz_p0    = lead_zero[k];
                en_p0[k]     = 1'b1;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit_p0),
        .seg (pat_p0)
    );

    // The rightmost digit always shows, so a zero value reads as "0" rather than dark.
    assign blank_p0 = blank_lz && cur_lz_p0 && (idx != '0);
    assign seg_p0   = blank_p0 ? SEG_OFF : pat_p0;

    // Output register: polarity applied here so reset also lands at the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= {7{INVERT}};
            digit_en <= {NUM_DIGITS{INVERT}};
        end else begin
            seg      <= seg_p0 ^ {7{INVERT}};
            digit_en <= en_p0 ^ {NUM_DIGITS{INVERT}};
        end
    end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream display stage for the binary-to-BCD converter. Captures a packed vector of BCD digits on a load strobe, decodes each digit to 7-segment patterns and time-multiplexes them onto one shared segment bus with per-digit enables. Registered outputs drive the board's multiplexed 7-segment display directly. Includes optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8)
SCAN_DIV, 50000, clk cycles each digit stays lit (>=2)
COMMON_ANODE, 0, 0: seg/digit_en active-high; 1: both active-low

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bcd_in  input  4*NUM_DIGITS  packed BCD digits, digit k = bcd_in[4k+3:4k], digit 0 rightmost
load  input  1  capture bcd_in into shadow register at this clk edge
blank_lz  input  1  1: blank leading zeros
seg  output  7  segment pattern {g,f,e,d,c,b,a}, registered
digit_en  output  NUM_DIGITS  one-hot digit select, registered

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: prescaler=0, digit index=0, shadow=all zero; seg and digit_en at inactive level (all 0, or all 1 when COMMON_ANODE=1).
- Shadow: load=1 at an edge stores bcd_in; otherwise held. Load does not restart the scan.
- Prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and digit index advances; index NUM_DIGITS-1 wraps to 0.
- Output register updates every cycle from current index and current shadow: 1-cycle latency. First edge after reset release drives digit 0; a load at edge N is visible on seg at edge N+1.
- digit_en: exactly one bit active, bit = index. No dark gap between digits.
- Decode (active-high form): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; codes 10..15 = 0x40 (dash, error indication).
- Blanking: when blank_lz=1, digit k>0 shows 0x00 if it and all higher digits equal 0. Digit 0 is never blanked. An invalid code is non-zero and stops blanking.
- COMMON_ANODE=1: seg and digit_en are bitwise inverted at the output register, reset value included.
- Reset asserted mid-scan: immediate return to reset values, shadow cleared.

Decomposition:
- Package seg7_pkg: segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF; a clog2-based index-width function.
- Sub-module bcd_to_seg7: combinational 4-bit BCD to 7-bit pattern, reusable by single-digit displays.
- Prescaler, index counter, shadow register, blanking logic and output register stay in the top module.

Test Plan:
- Reset then scan (SCAN_DIV=4, NUM_DIGITS=4): load 0x1234. Edge-by-edge checks:
  - digit_en = 0001 with seg 0x66 for 4 cycles;
  - then 0010 with seg 0x4F;
  - then 0100 with seg 0x5B;
  - then 1000 with seg 0x06;
  - then wraps to 0001.
- Leading-zero blanking: load 0x0070 with blank_lz=1. Required: digit0=0x3F, digit1=0x07, digit2=0x00, digit3=0x00. Load 0x0000: digit0=0x3F, all other digits 0x00. With blank_lz=0, 0x0000 shows 0x3F on every digit.
- Invalid code: load 0x00A5 with blank_lz=1. Required: digit0=0x6D, digit1=0x40, digit2=0x00, digit3=0x00.
- Mid-scan load: load 0x1111, then load 0x9999 while digit 2 is active. Required: seg changes 0x06 to 0x6F exactly one edge after the load, digit_en unchanged, prescaler phase unchanged.
- Async reset: assert rst_n=0 between clock edges mid-scan. Required: seg=0x00 and digit_en=0000 immediately. After release, one edge gives digit_en=0001 with seg 0x3F (shadow cleared).
- COMMON_ANODE=1: check reset outputs are seg=0x7F and digit_en=1111. Load 0x0008: digit0 gives seg=0x00 and digit_en=1110.
